// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types, constants and decode helper for the Z80 bus controller
package z80_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM,
    ST_RAM,
    ST_IO,
    ST_HOLD
  } state_t;

  localparam int         BORDER_LSB = 0;
  localparam int         BEEP_BIT   = 4;
  localparam logic [7:0] DI_IDLE    = 8'hFF;

  // True when the top rom_bits address bits are all zero (boot ROM window)
  function automatic logic in_rom(input logic [15:0] a, input int rom_bits);
    logic [15:0] mask;
    mask = ~(16'hFFFF >> rom_bits);
    return (a & mask) == 16'h0000;
  endfunction

endpackage

// File: rtl/z80_mem_ctrl_if.sv
// rtl/z80_mem_ctrl_if.sv - Z80 CPU bus signals shared by the core and the bus controller
interface z80_mem_ctrl_if;
  logic [15:0] z_a;
  logic [7:0]  z_do;
  logic [7:0]  z_di;
  logic        z_mreq_n;
  logic        z_iorq_n;
  logic        z_rd_n;
  logic        z_wr_n;
  logic        z_m1_n;
  logic        z_wait_n;

  modport master (
    output z_a, z_do, z_mreq_n, z_iorq_n, z_rd_n, z_wr_n, z_m1_n,
    input  z_di, z_wait_n
  );

  modport slave (
    input  z_a, z_do, z_mreq_n, z_iorq_n, z_rd_n, z_wr_n, z_m1_n,
    output z_di, z_wait_n
  );
endinterface

// File: rtl/z80_ram_hs.sv
// rtl/z80_ram_hs.sv - SRAM request/acknowledge handshake with timeout counter
module z80_ram_hs
  import z80_bus_pkg::*;
#(
  parameter int RAM_TO = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we_in,
  input  logic [15:0] a_in,
  input  logic [7:0]  wd_in,
  input  logic        ram_ack,
  output logic        ram_req,
  output logic        ram_we,
  output logic [15:0] ram_a,
  output logic [7:0]  ram_wd,
  output logic        done,
  output logic        timeout
);

  localparam logic [7:0] TO_LAST = 8'(RAM_TO - 1);

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  wd_q, wd_d;
  logic [7:0]  cnt_q, cnt_d;

  // An ack only counts while a request is outstanding; ack beats timeout
  assign done    = req_q & ram_ack;
  assign timeout = req_q & ~ram_ack & (cnt_q == TO_LAST);

  assign ram_req = req_q;
  assign ram_we  = we_q;
  assign ram_a   = a_q;
  assign ram_wd  = wd_q;

  // Launch a request on start, count cycles while pending, drop on ack or timeout
  always_comb begin
    req_d = req_q;
    we_d  = we_q;
    a_d   = a_q;
    wd_d  = wd_q;
    cnt_d = cnt_q;
    if (start) begin
      req_d = 1'b1;
      we_d  = we_in;
      a_d   = a_in;
      wd_d  = wd_in;
      cnt_d = 8'd0;
    end else if (req_q) begin
      if (done || timeout) begin
        req_d = 1'b0;
        we_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
      a_q   <= 16'h0000;
      wd_q  <= 8'h00;
      cnt_q <= 8'd0;
    end else begin
      req_q <= req_d;
      we_q  <= we_d;
      a_q   <= a_d;
      wd_q  <= wd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/z80_mem_ctrl.sv
// rtl/z80_mem_ctrl.sv - Z80 bus controller: ROM/SRAM/IO decode, wait states, port 0xFE
module z80_mem_ctrl
  import z80_bus_pkg::*;
#(
  parameter int ROM_BITS = 2,
  parameter int ROM_WS   = 1,
  parameter int RAM_TO   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  z80_mem_ctrl_if.slave        bus,
  output logic [15:0]          rom_a,
  input  logic [7:0]           rom_d,
  output logic [15:0]          ram_a,
  output logic [7:0]           ram_wd,
  input  logic [7:0]           ram_rd,
  output logic                 ram_req,
  output logic                 ram_we,
  input  logic                 ram_ack,
  output logic [2:0]           border,
  output logic                 beeper,
  output logic                 io_wr,
  output logic [15:0]          io_a,
  output logic [7:0]           io_d,
  output logic                 bus_err
);

  localparam logic [2:0] ROM_CNT_INIT = (ROM_WS > 0) ? 3'(ROM_WS - 1) : 3'd0;

  state_t      state_q, state_d;
  logic [7:0]  z_di_q, z_di_d;
  logic        wait_n_q, wait_n_d;
  logic [2:0]  rom_cnt_q, rom_cnt_d;
  logic [2:0]  border_q, border_d;
  logic        beeper_q, beeper_d;
  logic        io_wr_q, io_wr_d;
  logic [15:0] io_a_q, io_a_d;
  logic [7:0]  io_d_q, io_d_d;
  logic        bus_err_q, bus_err_d;
  logic        mem_q, io_q, inta_q;

  logic mem, io, inta;
  logic mem_start, io_start, inta_start;
  logic ram_start, ram_done, ram_timeout;

  // Same clock as the CPU, so strobes are decoded directly without synchronisers
  assign mem  = ~bus.z_mreq_n & (~bus.z_rd_n | ~bus.z_wr_n);
  assign io   = ~bus.z_iorq_n & bus.z_m1_n & (~bus.z_rd_n | ~bus.z_wr_n);
  assign inta = ~bus.z_iorq_n & ~bus.z_m1_n;

  assign mem_start  = mem & ~mem_q;
  assign io_start   = io & ~io_q;
  assign inta_start = inta & ~inta_q;

  assign rom_a        = bus.z_a;
  assign bus.z_di     = z_di_q;
  assign bus.z_wait_n = wait_n_q;
  assign border       = border_q;
  assign beeper       = beeper_q;
  assign io_wr        = io_wr_q;
  assign io_a         = io_a_q;
  assign io_d         = io_d_q;
  assign bus_err      = bus_err_q;

  z80_ram_hs #(.RAM_TO(RAM_TO)) u_ram_hs (
    .clk     (clk),
    .rst     (rst),
    .start   (ram_start),
    .we_in   (~bus.z_wr_n),
    .a_in    (bus.z_a),
    .wd_in   (bus.z_do),
    .ram_ack (ram_ack),
    .ram_req (ram_req),
    .ram_we  (ram_we),
    .ram_a   (ram_a),
    .ram_wd  (ram_wd),
    .done    (ram_done),
    .timeout (ram_timeout)
  );

  // Bus-cycle FSM: one action per CPU bus cycle, HOLD waits for strobes to release
  always_comb begin
    state_d   = state_q;
    z_di_d    = z_di_q;
    wait_n_d  = wait_n_q;
    rom_cnt_d = rom_cnt_q;
    border_d  = border_q;
    beeper_d  = beeper_q;
    io_wr_d   = 1'b0;
    io_a_d    = io_a_q;
    io_d_d    = io_d_q;
    bus_err_d = bus_err_q;
    ram_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_start) begin
          if (in_rom(bus.z_a, ROM_BITS)) begin
            if (!bus.z_rd_n) begin
              if (ROM_WS == 0) begin
                z_di_d  = rom_d;
                state_d = ST_HOLD;
              end else begin
                wait_n_d  = 1'b0;
                rom_cnt_d = ROM_CNT_INIT;
                state_d   = ST_ROM;
              end
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            ram_start = 1'b1;
            wait_n_d  = 1'b0;
            state_d   = ST_RAM;
          end
        end else if (io_start) begin
          state_d = ST_IO;
        end else if (inta_start) begin
          z_di_d  = DI_IDLE;
          state_d = ST_HOLD;
        end
      end
      ST_ROM: begin
        if (rom_cnt_q == 3'd0) begin
          z_di_d   = rom_d;
          wait_n_d = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          rom_cnt_d = rom_cnt_q - 3'd1;
        end
      end
      ST_RAM: begin
        if (ram_done) begin
          if (!ram_we) z_di_d = ram_rd;
          wait_n_d = 1'b1;
          state_d  = ST_HOLD;
        end else if (ram_timeout) begin
          z_di_d    = DI_IDLE;
          bus_err_d = 1'b1;
          wait_n_d  = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_IO: begin
        if (!bus.z_wr_n) begin
          if (!bus.z_a[0]) begin
            border_d = bus.z_do[BORDER_LSB +: 3];
            beeper_d = bus.z_do[BEEP_BIT];
          end else begin
            io_a_d  = bus.z_a;
            io_d_d  = bus.z_do;
            io_wr_d = 1'b1;
          end
        end else begin
          z_di_d = DI_IDLE;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.z_rd_n && bus.z_wr_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, registered outputs and previous-cycle strobe decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      z_di_q    <= DI_IDLE;
      wait_n_q  <= 1'b1;
      rom_cnt_q <= 3'd0;
      border_q  <= 3'd0;
      beeper_q  <= 1'b0;
      io_wr_q   <= 1'b0;
      io_a_q    <= 16'h0000;
      io_d_q    <= 8'h00;
      bus_err_q <= 1'b0;
      mem_q     <= 1'b0;
      io_q      <= 1'b0;
      inta_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_di_q    <= z_di_d;
      wait_n_q  <= wait_n_d;
      rom_cnt_q <= rom_cnt_d;
      border_q  <= border_d;
      beeper_q  <= beeper_d;
      io_wr_q   <= io_wr_d;
      io_a_q    <= io_a_d;
      io_d_q    <= io_d_d;
      bus_err_q <= bus_err_d;
      mem_q     <= mem;
      io_q      <= io;
      inta_q    <= inta;
    end
  end

endmodule

// File: tb/tb_z80_mem_ctrl.sv
// tb/tb_z80_mem_ctrl.sv - directed self-checking bench for z80_mem_ctrl
module tb_z80_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] rom_a;
  logic [7:0]  rom_d;
  logic [15:0] ram_a;
  logic [7:0]  ram_wd;
  logic [7:0]  ram_rd;
  logic        ram_req;
  logic        ram_we;
  logic        ram_ack;
  logic [2:0]  border;
  logic        beeper;
  logic        io_wr;
  logic [15:0] io_a;
  logic [7:0]  io_d;
  logic        bus_err;

  int          pass_cnt;
  int          total_cnt;
  logic [7:0]  sram_byte;

  z80_mem_ctrl_if bus ();

  z80_mem_ctrl #(.ROM_BITS(2), .ROM_WS(1), .RAM_TO(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .rom_a   (rom_a),
    .rom_d   (rom_d),
    .ram_a   (ram_a),
    .ram_wd  (ram_wd),
    .ram_rd  (ram_rd),
    .ram_req (ram_req),
    .ram_we  (ram_we),
    .ram_ack (ram_ack),
    .border  (border),
    .beeper  (beeper),
    .io_wr   (io_wr),
    .io_a    (io_a),
    .io_d    (io_d),
    .bus_err (bus_err)
  );

  // ROM model: address 0x0000 holds 0xF3, generally data = low byte ^ 0xF3
  assign rom_d = rom_a[7:0] ^ 8'hF3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_release;
    bus.z_mreq_n = 1'b1;
    bus.z_iorq_n = 1'b1;
    bus.z_rd_n   = 1'b1;
    bus.z_wr_n   = 1'b1;
    bus.z_m1_n   = 1'b1;
  endtask

  task automatic idle(input int n);
    bus_release;
    repeat (n) tick;
  endtask

  // Drives one SRAM cycle; SRAM model acks on the ack_at-th request cycle (0 = never)
  task automatic run_ram(input logic wr, input logic [15:0] a, input logic [7:0] d,
                         input int ack_at, output int req_cycles,
                         output logic we_seen, output logic wait_hi);
    bus.z_a      = a;
    bus.z_do     = d;
    bus.z_mreq_n = 1'b0;
    if (wr) bus.z_wr_n = 1'b0;
    else    bus.z_rd_n = 1'b0;
    req_cycles = 0;
    we_seen    = 1'b0;
    wait_hi    = 1'b0;
    tick;
    for (int c = 0; c < 12; c++) begin
      if (ram_req !== 1'b1) break;
      req_cycles++;
      we_seen = ram_we;
      if (bus.z_wait_n !== 1'b0) wait_hi = 1'b1;
      if (req_cycles == ack_at) begin
        ram_ack = 1'b1;
        if (wr) sram_byte = ram_wd;
        ram_rd = sram_byte;
      end
      tick;
      ram_ack = 1'b0;
      ram_rd  = 8'h00;
    end
  endtask

  task automatic rom_read(input logic [15:0] a, input logic m1_n);
    bus.z_a      = a;
    bus.z_m1_n   = m1_n;
    bus.z_mreq_n = 1'b0;
    bus.z_rd_n   = 1'b0;
    tick;
    tick;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                          output int pulses);
    bus.z_a      = a;
    bus.z_do     = d;
    bus.z_m1_n   = 1'b1;
    bus.z_iorq_n = 1'b0;
    bus.z_wr_n   = 1'b0;
    pulses = 0;
    repeat (hold) begin
      tick;
      if (io_wr === 1'b1) pulses++;
    end
    bus_release;
    repeat (3) begin
      tick;
      if (io_wr === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ram_ack = 1'b0;
    ram_rd = 8'h00;
    bus.z_a = 16'h0000;
    bus.z_do = 8'h00;
    bus_release;
    tick;
    tick;
    rst = 1'b0;
    if (bus.z_di !== 8'hFF) $display("FAIL reset_z_di: got %h expected ff", bus.z_di); else pass_cnt++;
    total_cnt++;
    if (bus.z_wait_n !== 1'b1) $display("FAIL reset_wait_n: got %b expected 1", bus.z_wait_n); else pass_cnt++;
    total_cnt++;
    if ({ram_req, ram_we, io_wr, bus_err, beeper} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {ram_req, ram_we, io_wr, bus_err, beeper}); else pass_cnt++;
    total_cnt++;
    if (border !== 3'b000) $display("FAIL reset_border: got %b expected 000", border); else pass_cnt++;
    total_cnt++;
    if ({io_a, io_d} !== 24'h0) $display("FAIL reset_io_latch: got %h expected 000000", {io_a, io_d}); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_rom_fetch;
    bus.z_a      = 16'h0000;
    bus.z_m1_n   = 1'b0;
    bus.z_mreq_n = 1'b0;
    bus.z_rd_n   = 1'b0;
    #1;
    if (rom_a !== 16'h0000) $display("FAIL rom_a: got %h expected 0000", rom_a); else pass_cnt++;
    total_cnt++;
    tick;
    if (bus.z_wait_n !== 1'b0) $display("FAIL rom_wait_low: got %b expected 0", bus.z_wait_n); else pass_cnt++;
    total_cnt++;
    if (bus.z_di !== 8'hFF) $display("FAIL rom_di_early: got %h expected ff", bus.z_di); else pass_cnt++;
    total_cnt++;
    tick;
    if (bus.z_wait_n !== 1'b1) $display("FAIL rom_wait_release: got %b expected 1", bus.z_wait_n); else pass_cnt++;
    total_cnt++;
    if (bus.z_di !== 8'hF3) $display("FAIL rom_fetch_data: got %h expected f3", bus.z_di); else pass_cnt++;
    total_cnt++;
    idle(2);
  endtask

  task automatic test_ram_wr_rd;
    int   rc;
    logic we_s;
    logic wait_hi;
    run_ram(1'b1, 16'h8000, 8'h5A, 3, rc, we_s, wait_hi);
    if (rc !== 3) $display("FAIL ram_wr_req_cycles: got %0d expected 3", rc); else pass_cnt++;
    total_cnt++;
    if (we_s !== 1'b1) $display("FAIL ram_wr_we: got %b expected 1", we_s); else pass_cnt++;
    total_cnt++;
    if (wait_hi !== 1'b0) $display("FAIL ram_wr_wait_held: got %b expected 0", wait_hi); else pass_cnt++;
    total_cnt++;
    if ({ram_a, ram_wd} !== 24'h80005A) $display("FAIL ram_wr_addr_data: got %h expected 80005a", {ram_a, ram_wd}); else pass_cnt++;
    total_cnt++;
    if (bus.z_wait_n !== 1'b1) $display("FAIL ram_wr_wait_release: got %b expected 1", bus.z_wait_n); else pass_cnt++;
    total_cnt++;
    idle(2);
    run_ram(1'b0, 16'h8000, 8'h00, 3, rc, we_s, wait_hi);
    if (rc !== 3) $display("FAIL ram_rd_req_cycles: got %0d expected 3", rc); else pass_cnt++;
    total_cnt++;
    if (we_s !== 1'b0) $display("FAIL ram_rd_we: got %b expected 0", we_s); else pass_cnt++;
    total_cnt++;
    if (bus.z_di !== 8'h5A) $display("FAIL ram_rd_data: got %h expected 5a", bus.z_di); else pass_cnt++;
    total_cnt++;
    if (bus.z_wait_n !== 1'b1) $display("FAIL ram_rd_wait_release: got %b expected 1", bus.z_wait_n); else pass_cnt++;
    total_cnt++;
    idle(2);
  endtask

  task automatic test_timeout;
    int   rc;
    logic we_s;
    logic wait_hi;
    if (bus_err !== 1'b0) $display("FAIL bus_err_pre: got %b expected 0", bus_err); else pass_cnt++;
    total_cnt++;
    run_ram(1'b0, 16'hC000, 8'h00, 0, rc, we_s, wait_hi);
    if (rc !== 4) $display("FAIL timeout_req_cycles: got %0d expected 4", rc); else pass_cnt++;
    total_cnt++;
    if (bus.z_di !== 8'hFF) $display("FAIL timeout_z_di: got %h expected ff", bus.z_di); else pass_cnt++;
    total_cnt++;
    if (bus_err !== 1'b1) $display("FAIL timeout_bus_err: got %b expected 1", bus_err); else pass_cnt++;
    total_cnt++;
    if (bus.z_wait_n !== 1'b1) $display("FAIL timeout_wait_release: got %b expected 1", bus.z_wait_n); else pass_cnt++;
    total_cnt++;
    ram_ack = 1'b1;
    ram_rd  = 8'h77;
    tick;
    ram_ack = 1'b0;
    ram_rd  = 8'h00;
    tick;
    if ({ram_req, bus_err, bus.z_di} !== 10'b01_1111_1111) $display("FAIL late_ack: got %b expected 0111111111", {ram_req, bus_err, bus.z_di}); else pass_cnt++;
    total_cnt++;
    idle(2);
  endtask

  task automatic test_io_write;
    int p;
    io_write(16'h00FE, 8'h17, 3, p);
    if ({border, beeper} !== 4'b1111) $display("FAIL io_fe_border_beep: got %b expected 1111", {border, beeper}); else pass_cnt++;
    total_cnt++;
    if (p !== 0) $display("FAIL io_fe_no_pulse: got %0d expected 0", p); else pass_cnt++;
    total_cnt++;
    io_write(16'h55AA, 8'h0F, 3, p);
    if ({border, beeper} !== 4'b1110) $display("FAIL io_even_border_beep: got %b expected 1110", {border, beeper}); else pass_cnt++;
    total_cnt++;
    if (p !== 0) $display("FAIL io_even_no_pulse: got %0d expected 0", p); else pass_cnt++;
    total_cnt++;
    io_write(16'h55AB, 8'h42, 3, p);
    if (p !== 1) $display("FAIL io_odd_pulse: got %0d expected 1", p); else pass_cnt++;
    total_cnt++;
    if ({io_a, io_d} !== 24'h55AB42) $display("FAIL io_odd_latch: got %h expected 55ab42", {io_a, io_d}); else pass_cnt++;
    total_cnt++;
    if ({border, beeper} !== 4'b1110) $display("FAIL io_odd_border_kept: got %b expected 1110", {border, beeper}); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_strobe_hold;
    int p;
    io_write(16'h12FF, 8'h99, 10, p);
    if (p !== 1) $display("FAIL hold_single_pulse: got %0d expected 1", p); else pass_cnt++;
    total_cnt++;
    if ({io_a, io_d} !== 24'h12FF99) $display("FAIL hold_latch: got %h expected 12ff99", {io_a, io_d}); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_rom_write_and_reads;
    logic req_seen;
    logic wait_lo;
    rom_read(16'h0005, 1'b1);
    if (bus.z_di !== 8'hF6) $display("FAIL rom_read_0005: got %h expected f6", bus.z_di); else pass_cnt++;
    total_cnt++;
    idle(2);
    bus.z_a      = 16'h1000;
    bus.z_do     = 8'hAA;
    bus.z_mreq_n = 1'b0;
    bus.z_wr_n   = 1'b0;
    req_seen = 1'b0;
    wait_lo  = 1'b0;
    repeat (4) begin
      tick;
      if (ram_req !== 1'b0) req_seen = 1'b1;
      if (bus.z_wait_n !== 1'b1) wait_lo = 1'b1;
    end
    if ({req_seen, wait_lo} !== 2'b00) $display("FAIL rom_write_ignored: got %b expected 00", {req_seen, wait_lo}); else pass_cnt++;
    total_cnt++;
    if (bus.z_di !== 8'hF6) $display("FAIL rom_write_z_di_kept: got %h expected f6", bus.z_di); else pass_cnt++;
    total_cnt++;
    idle(2);
    bus.z_m1_n   = 1'b0;
    bus.z_iorq_n = 1'b0;
    tick;
    if (bus.z_di !== 8'hFF) $display("FAIL inta_z_di: got %h expected ff", bus.z_di); else pass_cnt++;
    total_cnt++;
    idle(2);
    rom_read(16'h0011, 1'b1);
    if (bus.z_di !== 8'hE2) $display("FAIL rom_read_0011: got %h expected e2", bus.z_di); else pass_cnt++;
    total_cnt++;
    idle(2);
    bus.z_a      = 16'h00FE;
    bus.z_iorq_n = 1'b0;
    bus.z_rd_n   = 1'b0;
    tick;
    if (bus.z_wait_n !== 1'b1) $display("FAIL io_read_no_wait: got %b expected 1", bus.z_wait_n); else pass_cnt++;
    total_cnt++;
    tick;
    if (bus.z_di !== 8'hFF) $display("FAIL io_read_z_di: got %h expected ff", bus.z_di); else pass_cnt++;
    total_cnt++;
    idle(2);
  endtask

  task automatic test_reset_mid_access;
    rom_read(16'h0011, 1'b1);
    idle(2);
    bus.z_a      = 16'h9000;
    bus.z_mreq_n = 1'b0;
    bus.z_rd_n   = 1'b0;
    tick;
    if ({ram_req, bus.z_wait_n} !== 2'b10) $display("FAIL mid_ram_pending: got %b expected 10", {ram_req, bus.z_wait_n}); else pass_cnt++;
    total_cnt++;
    tick;
    rst = 1'b1;
    tick;
    if ({ram_req, bus.z_wait_n, bus_err, beeper} !== 4'b0100) $display("FAIL mid_rst_flags: got %b expected 0100", {ram_req, bus.z_wait_n, bus_err, beeper}); else pass_cnt++;
    total_cnt++;
    if ({bus.z_di, border, io_a} !== {8'hFF, 3'b000, 16'h0000}) $display("FAIL mid_rst_regs: got %h expected %h", {bus.z_di, border, io_a}, {8'hFF, 3'b000, 16'h0000}); else pass_cnt++;
    total_cnt++;
    bus_release;
    rst     = 1'b0;
    ram_ack = 1'b1;
    ram_rd  = 8'h33;
    tick;
    ram_ack = 1'b0;
    ram_rd  = 8'h00;
    tick;
    if ({ram_req, bus.z_wait_n, bus.z_di} !== 10'b01_1111_1111) $display("FAIL mid_late_ack: got %b expected 0111111111", {ram_req, bus.z_wait_n, bus.z_di}); else pass_cnt++;
    total_cnt++;
    rom_read(16'h0000, 1'b0);
    if (bus.z_di !== 8'hF3) $display("FAIL post_rst_fetch: got %h expected f3", bus.z_di); else pass_cnt++;
    total_cnt++;
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    sram_byte = 8'h00;
    test_reset;
    test_rom_fetch;
    test_ram_wr_rd;
    test_timeout;
    test_io_write;
    test_strobe_hold;
    test_rom_write_and_reads;
    test_reset_mid_access;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/z80_mem_ctrl.md
Name: z80_mem_ctrl

Overview:
Z80 bus controller that sits between the soft Z80 core and its memory/IO targets.
- Decodes each CPU bus cycle to boot ROM, external SRAM or IO.
- Drives the ROM address and returns data to the CPU.
- Inserts wait states while the SRAM request/acknowledge handshake is pending.
- Holds the ULA-style port 0xFE register (border, beeper).
- The CPU runs on the same clock as this block, so bus strobes are not resynchronised.

Parameters:
ROM_BITS, 2, ROM occupies addresses where z_a[15:16-ROM_BITS] == 0 (default 0x0000-0x3FFF)
ROM_WS, 1, wait cycles inserted on a ROM read (0..7)
RAM_TO, 255, cycles to wait for ram_ack before aborting (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
z_a  in  16  CPU address
z_do  in  8  CPU data out
z_di  out  8  data to CPU
z_mreq_n  in  1  memory request
z_iorq_n  in  1  IO request
z_rd_n  in  1  read strobe
z_wr_n  in  1  write strobe
z_m1_n  in  1  M1 (opcode fetch / interrupt acknowledge)
z_wait_n  out  1  wait to CPU, active-low
rom_a  out  16  ROM address
rom_d  in  8  ROM data, combinational from rom_a
ram_a  out  16  SRAM address
ram_wd  out  8  SRAM write data
ram_rd  in  8  SRAM read data, valid with ram_ack
ram_req  out  1  SRAM request
ram_we  out  1  SRAM write enable, qualifies ram_req
ram_ack  in  1  SRAM done, single-cycle pulse
border  out  3  border colour
beeper  out  1  beeper bit
io_wr  out  1  one-cycle pulse for IO writes to odd ports
io_a  out  16  latched IO address
io_d  out  8  latched IO write data
bus_err  out  1  sticky SRAM timeout flag

Behaviour:
- Reset values: z_di=0xFF, z_wait_n=1, ram_req=0, ram_we=0, border=0, beeper=0, io_wr=0, io_a=0, io_d=0, bus_err=0, FSM in IDLE.
- rom_a = z_a, combinational.
- Access start: a strobe active in this cycle and not in the previous registered cycle.
  - mem = !mreq_n & (!rd_n | !wr_n)
  - io = !iorq_n & m1_n & (!rd_n | !wr_n)
  - inta = !iorq_n & !m1_n
- FSM states: IDLE, ROM, RAM, IO, HOLD.
- IDLE:
  - Start of a mem access to the ROM region: a read goes to ROM; a write is ignored and goes to HOLD.
  - Start of a mem access outside the ROM region goes to RAM.
  - Start of io goes to IO.
  - Start of inta: z_di=0xFF, go to HOLD.
- ROM:
  - z_wait_n=0 for ROM_WS cycles.
  - On the last wait cycle, z_di <= rom_d and z_wait_n returns to 1; go to HOLD.
  - With ROM_WS=0, there is no wait and z_di is registered in the start cycle.
- RAM:
  - In the start cycle: ram_req=1; ram_a, ram_wd and ram_we latched; z_wait_n=0; timeout counter cleared.
  - On ram_ack: ram_req=0; reads capture z_di <= ram_rd; z_wait_n=1 in the next cycle; go to HOLD.
  - If the counter reaches RAM_TO without ack: ram_req=0, z_di=0xFF, bus_err=1, release wait, go to HOLD.
  - An ack arriving in the same cycle as the timeout wins; bus_err is not set.
- IO:
  - Write to an even port (z_a[0]=0): border <= z_do[2:0], beeper <= z_do[4].
  - Write to an odd port: io_a/io_d latched, io_wr pulses for exactly 1 cycle.
  - Read of any port: z_di=0xFF.
  - No wait states; go to HOLD.
- HOLD: stay until both rd_n and wr_n are high, then go to IDLE. This guarantees one action per bus cycle even when the strobes stay low for many clocks.
- ram_ack in any state other than RAM is ignored.
- z_di holds its value between accesses.
- bus_err is cleared only by rst.
- rst mid-access: returns to IDLE in the next cycle, drops ram_req, z_wait_n=1. A late ram_ack is ignored.

Decomposition:
- Package z80_bus_pkg:
  - state enum
  - ROM region compare helper
  - port 0xFE bit positions (BORDER_LSB=0, BEEP_BIT=4)
  - reset constants (DI_IDLE=8'hFF)
- Sub-module z80_ram_hs: owns ram_req/ram_we/ram_a/ram_wd, the ack capture and the timeout counter. It exposes start, done and timeout to the FSM.

Test Plan:
- ROM fetch, ROM_WS=1: m1_n=0, mreq_n=0, rd_n=0, a=0x0000, ROM model returns 0xF3 -> wait_n low for 1 cycle, then z_di=0xF3; rom_a=0x0000.
- RAM write then read at 0x8000 of 0x5A, ack after 3 cycles -> ram_req high 3 cycles with ram_we=1 on the write; read returns z_di=0x5A; wait_n released 1 cycle after ack.
- IO write 0x17 to port 0x00FE -> border=3'b111, beeper=1, io_wr stays 0. Write 0x0F to port 0x55AA (even) -> border=3'b111, beeper=0, io_wr stays 0. Write 0x42 to port 0x55AB (odd) -> io_wr one-cycle pulse, io_a=0x55AB, io_d=0x42.
- SRAM timeout, RAM_TO=4, no ack -> ram_req drops after 4 cycles, z_di=0xFF, bus_err=1; a later ack causes no change.
- Strobe held 10 cycles on an odd-port IO write -> exactly one io_wr pulse. Write 0xAA to ROM address 0x1000 -> no ram_req, z_di unchanged.
- rst asserted during a RAM wait -> next cycle ram_req=0, wait_n=1, all outputs at reset values.
